// File: rtl/argon_pkg.sv
// rtl/argon_pkg.sv - shared Argon ALU encodings, instruction fields and sequencer states
package argon_pkg;

  localparam int ARGON_DATAWIDTH = 16;
  localparam int ARGON_OPWIDTH   = 3;
  localparam int ARGON_REGCOUNT  = 8;
  localparam int ARGON_IDXWIDTH  = 3;
  localparam int ARGON_INSTRW    = 16;

  localparam int OP_LSB   = 13;
  localparam int RD_LSB   = 10;
  localparam int RS1_LSB  = 7;
  localparam int RS2_LSB  = 4;
  localparam int RSVD_MSB = 3;

  typedef enum logic [2:0] {
    OP_ADD = 3'd0,
    OP_SUB = 3'd1,
    OP_AND = 3'd2,
    OP_OR  = 3'd3,
    OP_XOR = 3'd4,
    OP_SLL = 3'd5,
    OP_SRL = 3'd6,
    OP_SLT = 3'd7
  } op_e;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_READ  = 2'd1,
    ST_EXEC  = 2'd2,
    ST_WRITE = 2'd3
  } state_e;

  function automatic logic [2:0] instr_op(input logic [ARGON_INSTRW-1:0] instr);
    return instr[OP_LSB +: 3];
  endfunction

  function automatic logic [ARGON_IDXWIDTH-1:0] instr_rd(input logic [ARGON_INSTRW-1:0] instr);
    return instr[RD_LSB +: ARGON_IDXWIDTH];
  endfunction

  function automatic logic [ARGON_IDXWIDTH-1:0] instr_rs1(input logic [ARGON_INSTRW-1:0] instr);
    return instr[RS1_LSB +: ARGON_IDXWIDTH];
  endfunction

  function automatic logic [ARGON_IDXWIDTH-1:0] instr_rs2(input logic [ARGON_INSTRW-1:0] instr);
    return instr[RS2_LSB +: ARGON_IDXWIDTH];
  endfunction

  function automatic logic instr_rsvd_set(input logic [ARGON_INSTRW-1:0] instr);
    return |instr[RSVD_MSB:0];
  endfunction

endpackage

// File: rtl/argon_regfile.sv
// rtl/argon_regfile.sv - 8-entry register file, r0 hardwired zero, two captured read ports
module argon_regfile
  import argon_pkg::*;
#(
  parameter int DATAWIDTH = ARGON_DATAWIDTH,
  parameter int REGCOUNT  = ARGON_REGCOUNT,
  parameter int IDXWIDTH  = $clog2(REGCOUNT)
) (
  input  logic                 i_clk,
  input  logic                 i_rst,
  input  logic                 i_we,
  input  logic [IDXWIDTH-1:0]  i_waddr,
  input  logic [DATAWIDTH-1:0] i_wdata,
  input  logic                 i_re,
  input  logic [IDXWIDTH-1:0]  i_raddrA,
  input  logic [IDXWIDTH-1:0]  i_raddrB,
  output logic [DATAWIDTH-1:0] o_rdataA,
  output logic [DATAWIDTH-1:0] o_rdataB,
  input  logic [IDXWIDTH-1:0]  i_dbgAddr,
  output logic [DATAWIDTH-1:0] o_dbgRdata
);

  logic [DATAWIDTH-1:0] mem_q [REGCOUNT];
  logic [DATAWIDTH-1:0] rdataA_q;
  logic [DATAWIDTH-1:0] rdataB_q;

  // Entry 0 is never written, so it stays at its reset value of zero.
  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      for (int i = 0; i < REGCOUNT; i++) mem_q[i] <= '0;
      rdataA_q <= '0;
      rdataB_q <= '0;
    end else begin
      if (i_we && (i_waddr != '0)) mem_q[i_waddr] <= i_wdata;
      if (i_re) begin
        rdataA_q <= mem_q[i_raddrA];
        rdataB_q <= mem_q[i_raddrB];
      end
    end
  end

  assign o_rdataA   = rdataA_q;
  assign o_rdataB   = rdataB_q;
  assign o_dbgRdata = mem_q[i_dbgAddr];

endmodule

// File: rtl/argon_alu_issue.sv
// rtl/argon_alu_issue.sv - four-state issue sequencer feeding the Argon ALU and writing results back
module argon_alu_issue
  import argon_pkg::*;
#(
  parameter int DATAWIDTH = ARGON_DATAWIDTH,
  parameter int OPWIDTH   = ARGON_OPWIDTH,
  parameter int REGCOUNT  = ARGON_REGCOUNT
) (
  input  logic                   i_clk,
  input  logic                   i_rst,
  input  logic                   i_instrValid,
  output logic                   o_instrReady,
  input  logic [15:0]            i_instr,
  output logic [OPWIDTH-1:0]     o_aluOp,
  output logic [DATAWIDTH-1:0]   o_aluA,
  output logic [DATAWIDTH-1:0]   o_aluB,
  input  logic [DATAWIDTH-1:0]   i_aluResult,
  input  logic                   i_aluInvalidOp,
  output logic                   o_done,
  output logic                   o_fault,
  output logic [2:0]             o_wbAddr,
  output logic [DATAWIDTH-1:0]   o_wbData,
  input  logic                   i_dbgWe,
  input  logic [2:0]             i_dbgAddr,
  input  logic [DATAWIDTH-1:0]   i_dbgWdata,
  output logic [DATAWIDTH-1:0]   o_dbgRdata
);

  state_e                 state_q;
  logic [15:0]            instr_q;
  logic                   ready_q;
  logic                   done_q;
  logic                   fault_q;
  logic [OPWIDTH-1:0]     op_q;
  logic [2:0]             wbaddr_q;
  logic [DATAWIDTH-1:0]   wbdata_q;

  logic                   rf_we;
  logic [2:0]             rf_waddr;
  logic [DATAWIDTH-1:0]   rf_wdata;

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      state_q  <= ST_IDLE;
      instr_q  <= '0;
      ready_q  <= 1'b1;
      done_q   <= 1'b0;
      fault_q  <= 1'b0;
      op_q     <= '0;
      wbaddr_q <= '0;
      wbdata_q <= '0;
    end else begin
      done_q  <= 1'b0;
      fault_q <= 1'b0;
      case (state_q)
        ST_IDLE: begin
          if (i_instrValid) begin
            instr_q <= i_instr;
            ready_q <= 1'b0;
            state_q <= ST_READ;
          end
        end
        ST_READ: begin
          op_q    <= OPWIDTH'(instr_op(instr_q));
          state_q <= ST_EXEC;
        end
        ST_EXEC: begin
          // Reserved-bit faults report zero data regardless of what the ALU produced.
          wbaddr_q <= instr_rd(instr_q);
          wbdata_q <= instr_rsvd_set(instr_q) ? '0 : i_aluResult;
          done_q   <= 1'b1;
          fault_q  <= i_aluInvalidOp | instr_rsvd_set(instr_q);
          state_q  <= ST_WRITE;
        end
        ST_WRITE: begin
          ready_q <= 1'b1;
          state_q <= ST_IDLE;
        end
        default: state_q <= ST_IDLE;
      endcase
    end
  end

  // Debug writes land in IDLE, ahead of the READ of an instruction accepted on the same edge.
  always_comb begin
    rf_we    = 1'b0;
    rf_waddr = '0;
    rf_wdata = '0;
    if (state_q == ST_IDLE && i_dbgWe) begin
      rf_we    = 1'b1;
      rf_waddr = i_dbgAddr;
      rf_wdata = i_dbgWdata;
    end else if (state_q == ST_WRITE && !fault_q) begin
      rf_we    = 1'b1;
      rf_waddr = wbaddr_q;
      rf_wdata = wbdata_q;
    end
  end

  argon_regfile #(
    .DATAWIDTH (DATAWIDTH),
    .REGCOUNT  (REGCOUNT),
    .IDXWIDTH  (3)
  ) u_regfile (
    .i_clk      (i_clk),
    .i_rst      (i_rst),
    .i_we       (rf_we),
    .i_waddr    (rf_waddr),
    .i_wdata    (rf_wdata),
    .i_re       (state_q == ST_READ),
    .i_raddrA   (instr_rs1(instr_q)),
    .i_raddrB   (instr_rs2(instr_q)),
    .o_rdataA   (o_aluA),
    .o_rdataB   (o_aluB),
    .i_dbgAddr  (i_dbgAddr),
    .o_dbgRdata (o_dbgRdata)
  );

  assign o_instrReady = ready_q;
  assign o_aluOp      = op_q;
  assign o_done       = done_q;
  assign o_fault      = fault_q;
  assign o_wbAddr     = wbaddr_q;
  assign o_wbData     = wbdata_q;

endmodule

// File: tb/tb_argon_alu_issue.sv
// tb/tb_argon_alu_issue.sv - directed self-checking bench for argon_alu_issue
module tb_argon_alu_issue;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        instr_valid = 1'b0;
  logic        instr_ready;
  logic [15:0] instr = '0;
  logic [2:0]  alu_op;
  logic [15:0] alu_a, alu_b;
  logic [15:0] alu_result;
  logic        force_inv = 1'b0;
  logic        done, fault;
  logic [2:0]  wb_addr;
  logic [15:0] wb_data;
  logic        dbg_we = 1'b0;
  logic [2:0]  dbg_addr = '0;
  logic [15:0] dbg_wdata = '0;
  logic [15:0] dbg_rdata;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  // Reference ALU: unsigned compare for SLT, shift amount from B[3:0].
  always_comb begin
    alu_result = '0;
    case (alu_op)
      3'd0: alu_result = alu_a + alu_b;
      3'd1: alu_result = alu_a - alu_b;
      3'd2: alu_result = alu_a & alu_b;
      3'd3: alu_result = alu_a | alu_b;
      3'd4: alu_result = alu_a ^ alu_b;
      3'd5: alu_result = alu_a << alu_b[3:0];
      3'd6: alu_result = alu_a >> alu_b[3:0];
      default: alu_result = (alu_a < alu_b) ? 16'd1 : 16'd0;
    endcase
  end

  argon_alu_issue dut (
    .i_clk          (clk),
    .i_rst          (rst),
    .i_instrValid   (instr_valid),
    .o_instrReady   (instr_ready),
    .i_instr        (instr),
    .o_aluOp        (alu_op),
    .o_aluA         (alu_a),
    .o_aluB         (alu_b),
    .i_aluResult    (alu_result),
    .i_aluInvalidOp (force_inv),
    .o_done         (done),
    .o_fault        (fault),
    .o_wbAddr       (wb_addr),
    .o_wbData       (wb_data),
    .i_dbgWe        (dbg_we),
    .i_dbgAddr      (dbg_addr),
    .i_dbgWdata     (dbg_wdata),
    .o_dbgRdata     (dbg_rdata)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    if (obs !== exp) begin
      errors++;
      $display("FAIL %s obs=0x%0h exp=0x%0h", tag, obs, exp);
    end
  endtask

  task automatic dbg_wr(input logic [2:0] a, input logic [15:0] d);
    @(negedge clk);
    dbg_we = 1'b1; dbg_addr = a; dbg_wdata = d;
    @(negedge clk);
    dbg_we = 1'b0;
  endtask

  task automatic dbg_rd(input string tag, input logic [2:0] a, input logic [15:0] exp);
    dbg_addr = a;
    #1;
    chk(tag, dbg_rdata, exp);
  endtask

  // Accept at T, then check T+1..T+4; a debug write to r6 is held outside IDLE and must be ignored.
  task automatic issue(input string tag, input logic [2:0] op, input logic [2:0] rd,
                       input logic [2:0] rs1, input logic [2:0] rs2, input logic [3:0] rsvd,
                       input logic inv, input logic dbg_on, input logic [2:0] dbg_a,
                       input logic [15:0] dbg_d, input logic [15:0] exp_a,
                       input logic [15:0] exp_b, input logic exp_fault,
                       input logic chk_data, input logic [15:0] exp_data);
    @(negedge clk);
    chk({tag, ".ready_T"}, instr_ready, 1);
    instr_valid = 1'b1;
    instr = {op, rd, rs1, rs2, rsvd};
    dbg_we = dbg_on; dbg_addr = dbg_a; dbg_wdata = dbg_d;
    @(negedge clk);
    instr_valid = 1'b0;
    dbg_we = 1'b1; dbg_addr = 3'd6; dbg_wdata = 16'hBEEF;
    force_inv = inv;
    chk({tag, ".ready_T1"}, instr_ready, 0);
    chk({tag, ".done_T1"}, done, 0);
    @(negedge clk);
    chk({tag, ".op_T2"}, alu_op, op);
    chk({tag, ".a_T2"}, alu_a, exp_a);
    chk({tag, ".b_T2"}, alu_b, exp_b);
    chk({tag, ".done_T2"}, done, 0);
    @(negedge clk);
    chk({tag, ".done_T3"}, done, 1);
    chk({tag, ".fault_T3"}, fault, exp_fault);
    chk({tag, ".wbaddr_T3"}, wb_addr, rd);
    if (chk_data) chk({tag, ".wbdata_T3"}, wb_data, exp_data);
    @(negedge clk);
    dbg_we = 1'b0;
    force_inv = 1'b0;
    chk({tag, ".ready_T4"}, instr_ready, 1);
    chk({tag, ".done_T4"}, done, 0);
    chk({tag, ".fault_T4"}, fault, 0);
  endtask

  initial begin
    int saw_done;
    repeat (2) @(negedge clk);
    chk("rst.ready", instr_ready, 1);
    chk("rst.done", done, 0);
    chk("rst.fault", fault, 0);
    chk("rst.aluop", alu_op, 0);
    chk("rst.alua", alu_a, 0);
    chk("rst.alub", alu_b, 0);
    chk("rst.wbaddr", wb_addr, 0);
    chk("rst.wbdata", wb_data, 0);
    rst = 1'b0;
    for (int i = 0; i < 8; i++) dbg_rd($sformatf("rst.r%0d", i), 3'(i), 16'h0000);

    // ADD r3 = 0x7FFF + 1
    dbg_wr(3'd1, 16'h7FFF);
    dbg_wr(3'd2, 16'h0001);
    issue("add", 3'd0, 3'd3, 3'd1, 3'd2, 4'h0, 1'b0, 1'b0, 3'd0, 16'h0,
          16'h7FFF, 16'h0001, 1'b0, 1'b1, 16'h8000);
    dbg_rd("add.r3", 3'd3, 16'h8000);

    // SUB wrap, then SLT (unsigned in the reference ALU)
    dbg_wr(3'd1, 16'h0000);
    dbg_wr(3'd5, 16'h0055);
    issue("sub", 3'd1, 3'd4, 3'd1, 3'd2, 4'h0, 1'b0, 1'b0, 3'd0, 16'h0,
          16'h0000, 16'h0001, 1'b0, 1'b1, 16'hFFFF);
    dbg_rd("sub.r4", 3'd4, 16'hFFFF);
    issue("slt", 3'd7, 3'd5, 3'd4, 3'd2, 4'h0, 1'b0, 1'b0, 3'd0, 16'h0,
          16'hFFFF, 16'h0001, 1'b0, 1'b1, 16'h0000);
    dbg_rd("slt.r5", 3'd5, 16'h0000);

    // r0 sink, plus debug write to r0 discarded
    dbg_wr(3'd1, 16'h0005);
    dbg_wr(3'd2, 16'h0006);
    dbg_wr(3'd0, 16'h1234);
    dbg_rd("dbg.r0", 3'd0, 16'h0000);
    issue("r0", 3'd0, 3'd0, 3'd1, 3'd2, 4'h0, 1'b0, 1'b0, 3'd0, 16'h0,
          16'h0005, 16'h0006, 1'b0, 1'b1, 16'h000B);
    dbg_rd("r0.r0", 3'd0, 16'h0000);

    // ALU invalid-op fault and reserved-bit fault leave r3 alone
    issue("inv", 3'd4, 3'd3, 3'd1, 3'd2, 4'h0, 1'b1, 1'b0, 3'd0, 16'h0,
          16'h0005, 16'h0006, 1'b1, 1'b0, 16'h0000);
    dbg_rd("inv.r3", 3'd3, 16'h8000);
    issue("rsvd", 3'd3, 3'd3, 3'd1, 3'd2, 4'h1, 1'b0, 1'b0, 3'd0, 16'h0,
          16'h0005, 16'h0006, 1'b1, 1'b1, 16'h0000);
    dbg_rd("rsvd.r3", 3'd3, 16'h8000);

    // SLL, then debug write coincident with accept is seen by READ
    dbg_wr(3'd1, 16'h0003);
    dbg_wr(3'd2, 16'h0004);
    issue("sll", 3'd5, 3'd7, 3'd1, 3'd2, 4'h0, 1'b0, 1'b0, 3'd0, 16'h0,
          16'h0003, 16'h0004, 1'b0, 1'b1, 16'h0030);
    dbg_rd("sll.r7", 3'd7, 16'h0030);
    issue("dbgacc", 3'd0, 3'd7, 3'd1, 3'd2, 4'h0, 1'b0, 1'b1, 3'd1, 16'h0100,
          16'h0100, 16'h0004, 1'b0, 1'b1, 16'h0104);
    dbg_rd("dbgacc.r7", 3'd7, 16'h0104);
    dbg_rd("dbgign.r6", 3'd6, 16'h0000);

    // Reset mid-stream clears every register
    @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    chk("rst2.ready", instr_ready, 1);
    for (int i = 0; i < 8; i++) dbg_rd($sformatf("rst2.r%0d", i), 3'(i), 16'h0000);

    // Reset while an instruction is in flight
    dbg_wr(3'd1, 16'h0005);
    dbg_wr(3'd2, 16'h0006);
    @(negedge clk);
    instr_valid = 1'b1;
    instr = {3'd0, 3'd7, 3'd1, 3'd2, 4'h0};
    @(negedge clk);
    instr_valid = 1'b0;
    @(negedge clk);
    rst = 1'b1;
    saw_done = 0;
    #1;
    if (done) saw_done++;
    @(negedge clk);
    rst = 1'b0;
    for (int i = 0; i < 4; i++) begin
      if (done) saw_done++;
      @(negedge clk);
    end
    chk("rstop.no_done", saw_done, 0);
    dbg_rd("rstop.r7", 3'd7, 16'h0000);
    dbg_wr(3'd1, 16'h0020);
    dbg_wr(3'd2, 16'h0003);
    issue("after", 3'd1, 3'd7, 3'd1, 3'd2, 4'h0, 1'b0, 1'b0, 3'd0, 16'h0,
          16'h0020, 16'h0003, 1'b0, 1'b1, 16'h001D);
    dbg_rd("after.r7", 3'd7, 16'h001D);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
